// File: rtl/ul_prb_packer.sv
// Uplink PRB packer: ping-pong PRB banks for NUM_ANT antennas, drained
// as one header plus six data words per antenna onto the CPRI buffer.
module ul_prb_packer #(
  parameter int NUM_ANT = 4,
  parameter int IQ_W    = 14,
  parameter int SHIFT_W = 4,
  parameter int ADDR_W  = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_vld,
  input  logic                        i_sop,
  input  logic                        i_eop,
  input  logic [NUM_ANT*2*IQ_W-1:0]   i_iq,
  input  logic [NUM_ANT*SHIFT_W-1:0]  i_shift,
  input  logic [NUM_ANT*8-1:0]        i_info,
  input  logic [3:0]                  i_ch_type,
  input  logic [6:0]                  i_slot_idx,
  input  logic [3:0]                  i_sym_idx,
  input  logic [8:0]                  i_prb_idx,
  input  logic                        i_wr_ready,
  output logic                        o_cpri_wen,
  output logic [ADDR_W-1:0]           o_cpri_waddr,
  output logic [63:0]                 o_cpri_wdata,
  output logic                        o_cpri_wlast,
  output logic                        o_ovf,
  output logic                        o_err,
  output logic [15:0]                 o_drop_cnt
);

  localparam int RE_W = NUM_ANT * 2 * IQ_W;
  localparam logic [2:0] LAST_ANT = 3'(NUM_ANT - 1);

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } st_t;

  logic [RE_W-1:0]            mem     [2][12];
  logic [3:0]                 h_ch    [2];
  logic [6:0]                 h_slot  [2];
  logic [3:0]                 h_sym   [2];
  logic [8:0]                 h_prb   [2];
  logic [NUM_ANT*SHIFT_W-1:0] h_shift [2];
  logic [NUM_ANT*8-1:0]       h_info  [2];
  logic [1:0]                 h_sop;
  logic [1:0]                 h_eop;
  logic [1:0]                 full;

  logic       fill_bank;
  logic [3:0] re_cnt;
  logic       skip;

  logic       re0;
  logic       ovf;
  logic       sop_trunc;
  logic       cut;
  logic       eop_trunc;
  logic       eff_skip;
  logic       store;
  logic       done;
  logic [3:0] eff_cnt;

  st_t                 st;
  logic                rd_bank;
  logic [2:0]          ant;
  logic [2:0]          wk;
  logic                pend;
  logic [ADDR_W-1:0]   nxt_addr;
  logic [ADDR_W-1:0]   hdr_addr;
  logic                adv;
  logic                rel;
  logic [63:0]         hdr_w;
  logic [63:0]         dat_w;
  logic [3:0]          sh4;
  logic [RE_W-1:0]     row_e;
  logic [RE_W-1:0]     row_o;
  logic [2*IQ_W-1:0]   re_e;
  logic [2*IQ_W-1:0]   re_o;

  function automatic logic [15:0] sx(input logic [IQ_W-1:0] v);
    return 16'($signed(v));
  endfunction

  // A dropped PRB keeps counting REs in skip mode so its tail is ignored.
  always_comb begin
    re0       = i_vld && (i_sop || re_cnt == 4'd0);
    sop_trunc = i_vld && i_sop && re_cnt != 4'd0 && !skip;
    ovf       = re0 && full[fill_bank];
    eff_cnt   = re0 ? 4'd0 : re_cnt;
    eff_skip  = re0 ? ovf : skip;
    cut       = i_vld && i_eop && eff_cnt != 4'd11;
    eop_trunc = cut && !eff_skip;
    store     = i_vld && !cut && !eff_skip;
    done      = store && eff_cnt == 4'd11;
  end

  assign o_ovf = ovf;
  assign o_err = sop_trunc || eop_trunc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_cnt     <= '0;
      skip       <= 1'b0;
      fill_bank  <= 1'b0;
      full       <= '0;
      h_sop      <= '0;
      h_eop      <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (i_vld) begin
        if (cut || eff_cnt == 4'd11) begin
          re_cnt <= '0;
          skip   <= 1'b0;
        end else begin
          re_cnt <= eff_cnt + 4'd1;
          skip   <= eff_skip;
        end
      end
      if (store && re0)
        h_sop[fill_bank] <= i_sop;
      if (done) begin
        h_eop[fill_bank] <= i_eop;
        fill_bank        <= ~fill_bank;
      end
      for (int b = 0; b < 2; b++)
        full[b] <= (full[b] && !(rel && rd_bank == 1'(b)))
                || (done && fill_bank == 1'(b));
      if ((ovf || o_err) && o_drop_cnt != 16'hFFFF)
        o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (store)
      mem[fill_bank][eff_cnt] <= i_iq;
    if (store && re0) begin
      h_ch[fill_bank]    <= i_ch_type;
      h_slot[fill_bank]  <= i_slot_idx;
      h_sym[fill_bank]   <= i_sym_idx;
      h_prb[fill_bank]   <= i_prb_idx;
      h_shift[fill_bank] <= i_shift;
      h_info[fill_bank]  <= i_info;
    end
  end

  assign adv        = !pend || i_wr_ready;
  assign rel        = adv && st == DATA && wk == 3'd5 && ant == LAST_ANT;
  assign o_cpri_wen = pend && i_wr_ready;
  assign hdr_addr   = (ant == 3'd0 && h_sop[rd_bank]) ? '0 : nxt_addr;

  always_comb begin
    sh4 = '0;
    for (int b = 0; b < 4; b++)
      if (b < SHIFT_W)
        sh4[b] = h_shift[rd_bank][int'(ant)*SHIFT_W + b];
    hdr_w = {h_ch[rd_bank], ant, h_slot[rd_bank], h_sym[rd_bank],
             h_prb[rd_bank], sh4,
             h_info[rd_bank][int'(ant)*8 +: 8], 25'd0};
    row_e = mem[rd_bank][{wk, 1'b0}];
    row_o = mem[rd_bank][{wk, 1'b1}];
    re_e  = row_e[int'(ant)*2*IQ_W +: 2*IQ_W];
    re_o  = row_o[int'(ant)*2*IQ_W +: 2*IQ_W];
    dat_w = {sx(re_e[2*IQ_W-1:IQ_W]), sx(re_e[IQ_W-1:0]),
             sx(re_o[2*IQ_W-1:IQ_W]), sx(re_o[IQ_W-1:0])};
  end

  // The output register holds one word; it advances only once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= IDLE;
      rd_bank      <= 1'b0;
      ant          <= '0;
      wk           <= '0;
      pend         <= 1'b0;
      nxt_addr     <= '0;
      o_cpri_waddr <= '0;
      o_cpri_wdata <= '0;
      o_cpri_wlast <= 1'b0;
    end else if (adv) begin
      unique case (st)
        IDLE: begin
          if (full[rd_bank]) begin
            pend         <= 1'b1;
            o_cpri_wdata <= hdr_w;
            o_cpri_waddr <= hdr_addr;
            o_cpri_wlast <= 1'b0;
            nxt_addr     <= hdr_addr + 1'b1;
            wk           <= '0;
            st           <= DATA;
          end else begin
            pend         <= 1'b0;
            o_cpri_wlast <= 1'b0;
          end
        end
        HDR: begin
          pend         <= 1'b1;
          o_cpri_wdata <= hdr_w;
          o_cpri_waddr <= hdr_addr;
          o_cpri_wlast <= 1'b0;
          nxt_addr     <= hdr_addr + 1'b1;
          wk           <= '0;
          st           <= DATA;
        end
        DATA: begin
          pend         <= 1'b1;
          o_cpri_wdata <= dat_w;
          o_cpri_waddr <= nxt_addr;
          o_cpri_wlast <= wk == 3'd5 && ant == LAST_ANT && h_eop[rd_bank];
          nxt_addr     <= nxt_addr + 1'b1;
          if (wk == 3'd5) begin
            if (ant == LAST_ANT) begin
              ant     <= '0;
              rd_bank <= ~rd_bank;
              st      <= full[~rd_bank] ? HDR : IDLE;
            end else begin
              ant <= ant + 3'd1;
              st  <= HDR;
            end
          end else begin
            wk <= wk + 3'd1;
          end
        end
        default: begin
          pend <= 1'b0;
          st   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ul_prb_packer.sv
// Scoreboard bench for ul_prb_packer: expected words are queued as PRBs
// are driven and popped by a monitor on every observed write.
module tb_ul_prb_packer;

  localparam int A  = 4;
  localparam int W  = 14;
  localparam int SW = 4;
  localparam int AW = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_vld;
  logic              i_sop;
  logic              i_eop;
  logic [A*2*W-1:0]  i_iq;
  logic [A*SW-1:0]   i_shift;
  logic [A*8-1:0]    i_info;
  logic [3:0]        i_ch_type;
  logic [6:0]        i_slot_idx;
  logic [3:0]        i_sym_idx;
  logic [8:0]        i_prb_idx;
  logic              i_wr_ready;
  logic              o_cpri_wen;
  logic [AW-1:0]     o_cpri_waddr;
  logic [63:0]       o_cpri_wdata;
  logic              o_cpri_wlast;
  logic              o_ovf;
  logic              o_err;
  logic [15:0]       o_drop_cnt;

  ul_prb_packer #(
    .NUM_ANT(A), .IQ_W(W), .SHIFT_W(SW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_vld(i_vld), .i_sop(i_sop), .i_eop(i_eop),
    .i_iq(i_iq), .i_shift(i_shift), .i_info(i_info),
    .i_ch_type(i_ch_type), .i_slot_idx(i_slot_idx),
    .i_sym_idx(i_sym_idx), .i_prb_idx(i_prb_idx),
    .i_wr_ready(i_wr_ready),
    .o_cpri_wen(o_cpri_wen), .o_cpri_waddr(o_cpri_waddr),
    .o_cpri_wdata(o_cpri_wdata), .o_cpri_wlast(o_cpri_wlast),
    .o_ovf(o_ovf), .o_err(o_err), .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [63:0]   data;
    logic          last;
  } wr_t;

  wr_t          exp_q[$];
  logic [63:0]  cap[$];
  wr_t          m_got;
  wr_t          m_exp;
  int           n_cmp = 0;
  int           n_bad = 0;
  int           wr_cnt = 0;
  int           rdy_mode = 0;
  logic [AW-1:0] exp_addr = '0;

  logic [A*2*W-1:0] cur_iq [12];
  logic [3:0]       h_ch;
  logic [6:0]       h_slot;
  logic [3:0]       h_sym;
  logic [8:0]       h_prb;
  logic [A*SW-1:0]  h_sh;
  logic [A*8-1:0]   h_info;

  function automatic logic [15:0] sx(input logic [W-1:0] v);
    return {{(16-W){v[W-1]}}, v};
  endfunction

  function automatic logic [63:0] hdr_exp(input int a);
    return {h_ch, 3'(a), h_slot, h_sym, h_prb,
            h_sh[a*SW +: SW], h_info[a*8 +: 8], 25'd0};
  endfunction

  function automatic logic [63:0] dat_exp(input int a, input int k);
    logic [2*W-1:0] e;
    logic [2*W-1:0] o;
    e = cur_iq[2*k][a*2*W +: 2*W];
    o = cur_iq[2*k+1][a*2*W +: 2*W];
    return {sx(e[2*W-1:W]), sx(e[W-1:0]), sx(o[2*W-1:W]), sx(o[W-1:0])};
  endfunction

  task automatic rand_prb();
    logic [127:0] t;
    for (int r = 0; r < 12; r++) begin
      t = {$urandom, $urandom, $urandom, $urandom};
      cur_iq[r] = t[A*2*W-1:0];
    end
    h_ch   = 4'($urandom);
    h_slot = 7'($urandom);
    h_sym  = 4'($urandom);
    h_prb  = 9'($urandom);
    h_sh   = 16'($urandom);
    h_info = $urandom;
  endtask

  task automatic push_prb(input bit sop, input bit eop);
    wr_t w;
    for (int a = 0; a < A; a++)
      for (int k = 0; k < 7; k++) begin
        if (a == 0 && k == 0 && sop) exp_addr = '0;
        w.addr = exp_addr;
        w.data = (k == 0) ? hdr_exp(a) : dat_exp(a, k - 1);
        w.last = eop && a == A - 1 && k == 6;
        exp_q.push_back(w);
        exp_addr = exp_addr + 1'b1;
      end
  endtask

  task automatic send_prb(input int n, input bit sop, input bit eop,
                          output bit ovf0, output bit err_last);
    ovf0 = 1'b0;
    err_last = 1'b0;
    for (int r = 0; r < n; r++) begin
      i_vld      = 1'b1;
      i_sop      = sop && r == 0;
      i_eop      = eop && r == n - 1;
      i_iq       = cur_iq[r];
      i_shift    = h_sh;
      i_info     = h_info;
      i_ch_type  = h_ch;
      i_slot_idx = h_slot;
      i_sym_idx  = h_sym;
      i_prb_idx  = h_prb;
      @(negedge clk);
      if (r == 0) ovf0 = o_ovf;
      if (r == n - 1) err_last = o_err;
      @(posedge clk);
      #1;
    end
    i_vld = 1'b0;
    i_sop = 1'b0;
    i_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int budget, output int left);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    left = exp_q.size();
  endtask

  initial forever begin
    @(negedge clk);
    if (o_cpri_wen === 1'b1) begin
      m_got = {o_cpri_waddr, o_cpri_wdata, o_cpri_wlast};
      wr_cnt++;
      cap.push_back(o_cpri_wdata);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL extra_write: got addr=%0d data=%h, required no write",
                 o_cpri_waddr, o_cpri_wdata);
      end else begin
        m_exp = exp_q.pop_front();
        if (m_got !== m_exp) begin
          n_bad++;
          $display("FAIL word: got addr=%0d data=%h last=%b, required addr=%0d data=%h last=%b",
                   m_got.addr, m_got.data, m_got.last,
                   m_exp.addr, m_exp.data, m_exp.last);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       i_wr_ready = 1'b1;
      1:       i_wr_ready = ~i_wr_ready;
      default: i_wr_ready = 1'b0;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic test_reset();
    idle(3);
    n_cmp++;
    if ({o_cpri_wen, o_ovf, o_err, o_cpri_wlast} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b, required 0000",
               {o_cpri_wen, o_ovf, o_err, o_cpri_wlast});
    end
    n_cmp++;
    if (o_drop_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_drop_cnt: got %0d, required 0", o_drop_cnt);
    end
    n_cmp++;
    if ({o_cpri_waddr, o_cpri_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_addr_data: got %0d/%h, required 0/0",
               o_cpri_waddr, o_cpri_wdata);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    bit ov, er;
    int left, wc;
    wc = wr_cnt;
    rand_prb();
    push_prb(1'b1, 1'b1);
    send_prb(12, 1'b1, 1'b1, ov, er);
    @(negedge clk);
    n_cmp++;
    if (o_cpri_wen !== 1'b0) begin
      n_bad++;
      $display("FAIL latency_early: wen=%b one cycle after RE11, required 0", o_cpri_wen);
    end
    @(negedge clk);
    n_cmp++;
    if (o_cpri_wen !== 1'b1) begin
      n_bad++;
      $display("FAIL latency_first: wen=%b two cycles after RE11, required 1", o_cpri_wen);
    end
    @(posedge clk);
    #1;
    wait_drain(100, left);
    idle(5);
    n_cmp++;
    if (left != 0 || wr_cnt - wc != 28) begin
      n_bad++;
      $display("FAIL single_count: got %0d writes (%0d pending), required 28",
               wr_cnt - wc, left);
    end
  endtask

  task automatic test_sign_hdr();
    bit ov, er;
    int left;
    rand_prb();
    cur_iq[0][0*2*W +: 2*W] = {14'h2000, 14'h1FFF};
    cur_iq[0][2*2*W +: 2*W] = {14'h2000, 14'h1FFF};
    h_prb  = 9'd273;
    h_slot = 7'd5;
    h_sym  = 4'd13;
    cap.delete();
    push_prb(1'b1, 1'b0);
    send_prb(12, 1'b1, 1'b0, ov, er);
    wait_drain(100, left);
    idle(3);
    n_cmp++;
    if (cap.size() != 28) begin
      n_bad++;
      $display("FAIL sign_count: got %0d words, required 28", cap.size());
    end
    if (cap.size() >= 16) begin
      n_cmp++;
      if (cap[1][63:32] !== 32'hE0001FFF) begin
        n_bad++;
        $display("FAIL sign_ant0: got %h, required e0001fff", cap[1][63:32]);
      end
      n_cmp++;
      if (cap[15][63:32] !== 32'hE0001FFF) begin
        n_bad++;
        $display("FAIL sign_ant2: got %h, required e0001fff", cap[15][63:32]);
      end
      n_cmp++;
      if ({cap[14][59:57], cap[14][45:37], cap[14][56:50], cap[14][49:46]}
          !== {3'd2, 9'd273, 7'd5, 4'd13}) begin
        n_bad++;
        $display("FAIL hdr_fields: got ant=%0d prb=%0d slot=%0d sym=%0d, required 2/273/5/13",
                 cap[14][59:57], cap[14][45:37], cap[14][56:50], cap[14][49:46]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ov, er;
    int left, wc;
    wc = wr_cnt;
    rdy_mode = 1;
    for (int p = 0; p < 3; p++) begin
      rand_prb();
      push_prb(p == 0, p == 2);
      send_prb(12, p == 0, p == 2, ov, er);
      n_cmp++;
      if (ov !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_ovf: prb %0d ovf=%b, required 0", p, ov);
      end
      idle(50);
    end
    wait_drain(400, left);
    rdy_mode = 0;
    idle(5);
    n_cmp++;
    if (left != 0 || wr_cnt - wc != 84) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d writes (%0d pending), required 84",
               wr_cnt - wc, left);
    end
  endtask

  task automatic test_overflow();
    bit ov1, ov3, er;
    int left, wc;
    logic [15:0] d0;
    d0 = o_drop_cnt;
    wc = wr_cnt;
    rdy_mode = 2;
    idle(2);
    rand_prb();
    push_prb(1'b1, 1'b0);
    send_prb(12, 1'b1, 1'b0, ov1, er);
    rand_prb();
    push_prb(1'b0, 1'b0);
    send_prb(12, 1'b0, 1'b0, ov1, er);
    rand_prb();
    send_prb(12, 1'b0, 1'b1, ov3, er);
    n_cmp++;
    if (ov1 !== 1'b0 || ov3 !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_pulse: got prb2=%b prb3=%b, required 0/1", ov1, ov3);
    end
    n_cmp++;
    if (o_drop_cnt !== d0 + 16'd1) begin
      n_bad++;
      $display("FAIL ovf_drop_cnt: got %0d, required %0d", o_drop_cnt, d0 + 16'd1);
    end
    idle(4);
    rdy_mode = 0;
    wait_drain(200, left);
    idle(10);
    n_cmp++;
    if (left != 0 || wr_cnt - wc != 56) begin
      n_bad++;
      $display("FAIL ovf_count: got %0d writes (%0d pending), required 56",
               wr_cnt - wc, left);
    end
  endtask

  task automatic test_trunc();
    bit ov, er;
    int left, wc;
    logic [15:0] d0;
    d0 = o_drop_cnt;
    wc = wr_cnt;
    rand_prb();
    send_prb(8, 1'b1, 1'b1, ov, er);
    n_cmp++;
    if (er !== 1'b1) begin
      n_bad++;
      $display("FAIL trunc_err: got %b at RE7, required 1", er);
    end
    idle(10);
    n_cmp++;
    if (o_drop_cnt !== d0 + 16'd1 || wr_cnt != wc) begin
      n_bad++;
      $display("FAIL trunc_drop: got cnt=%0d writes=%0d, required %0d/0",
               o_drop_cnt, wr_cnt - wc, d0 + 16'd1);
    end
    rand_prb();
    push_prb(1'b1, 1'b1);
    send_prb(12, 1'b1, 1'b1, ov, er);
    wait_drain(100, left);
    idle(3);
    n_cmp++;
    if (left != 0) begin
      n_bad++;
      $display("FAIL trunc_next: %0d words pending, required 0", left);
    end
  endtask

  task automatic test_reset_mid();
    bit ov, er;
    int left, wc, t;
    wc = wr_cnt;
    rand_prb();
    push_prb(1'b1, 1'b1);
    send_prb(12, 1'b1, 1'b1, ov, er);
    t = 0;
    while (wr_cnt - wc < 10 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    n_cmp++;
    if (wr_cnt - wc != 10) begin
      n_bad++;
      $display("FAIL rst_mid_reach: got %0d writes, required 10", wr_cnt - wc);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_cpri_wen !== 1'b0 || o_drop_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_mid_wen: got wen=%b cnt=%0d, required 0/0",
               o_cpri_wen, o_drop_cnt);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_addr = '0;
    idle(2);
    rand_prb();
    push_prb(1'b0, 1'b0);
    send_prb(12, 1'b0, 1'b0, ov, er);
    wait_drain(100, left);
    idle(5);
    n_cmp++;
    if (left != 0) begin
      n_bad++;
      $display("FAIL rst_mid_after: %0d words pending, required 0", left);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    i_vld      = 1'b0;
    i_sop      = 1'b0;
    i_eop      = 1'b0;
    i_iq       = '0;
    i_shift    = '0;
    i_info     = '0;
    i_ch_type  = '0;
    i_slot_idx = '0;
    i_sym_idx  = '0;
    i_prb_idx  = '0;
    i_wr_ready = 1'b1;
    test_reset();
    test_single();
    test_sign_hdr();
    test_back_to_back();
    test_overflow();
    test_trunc();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
